// File: rtl/weight_ram_upload_if.sv
// Bundle between the readback engine, the weight RAM read port and the byte sink.
// Stream handshake: a byte moves on a rising edge where tx_valid and tx_ready are both high;
// once tx_valid is raised, tx_valid and tx_data hold steady until that edge.
interface weight_ram_upload_if #(
    parameter int N  = 10,
    parameter int W  = 10,
    parameter int AW = 7
);
    logic [AW-1:0]  address;
    logic           we;
    logic [N*W-1:0] q;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;

    modport master (
        output address, we, tx_data, tx_valid,
        input  q, tx_ready
    );

    modport slave (
        input  address, we, tx_data, tx_valid,
        output q, tx_ready
    );
endinterface

// File: rtl/weight_ram_upload.sv
// Weight RAM readback: sweeps every address and streams a header, hi/lo byte pairs
// for each lane, and an 8-bit additive checksum over the lane bytes.
module weight_ram_upload #(
    parameter int         N   = 10,
    parameter int         W   = 10,
    parameter int         AW  = 7,
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    weight_ram_upload_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg
);
    localparam int LW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_LATCH = 3'd3,
        S_SEND  = 3'd4,
        S_TRAIL = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [N*W-1:0] buf_q, buf_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic           lo_q, lo_d;
    logic [7:0]     csum_q, csum_d;

    logic [W-1:0]   lane_word;
    logic [15:0]    lane_ext;
    logic [7:0]     send_byte;
    logic [7:0]     tx_data;
    logic           tx_valid;

    // Lanes narrower than 16 bits are zero-extended so the hi byte carries only lane[W-1:8].
    always_comb begin
        lane_word = buf_q[lane_q*W +: W];
        lane_ext  = 16'(lane_word);
        send_byte = lo_q ? lane_ext[7:0] : lane_ext[15:8];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        buf_d    = buf_q;
        lane_d   = lane_q;
        lo_d     = lo_q;
        csum_d   = csum_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    addr_d  = '0;
                    csum_d  = 8'h00;
                    lane_d  = '0;
                    lo_d    = 1'b0;
                end
            end
            S_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HDR;
                if (bus.tx_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                busy    = 1'b1;
                buf_d   = bus.q;
                lane_d  = '0;
                lo_d    = 1'b0;
                state_d = S_SEND;
            end
            S_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = send_byte;
                if (bus.tx_ready) begin
                    csum_d = csum_q + send_byte;
                    if (!lo_q) begin
                        lo_d = 1'b1;
                    end else begin
                        lo_d = 1'b0;
                        if (lane_q == LW'(N - 1)) begin
                            if (addr_q == AW'(DEPTH - 1)) begin
                                state_d = S_TRAIL;
                            end else begin
                                addr_d  = addr_q + AW'(1);
                                state_d = S_FETCH;
                            end
                        end else begin
                            lane_d = lane_q + LW'(1);
                        end
                    end
                end
            end
            S_TRAIL: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (bus.tx_ready) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
            lane_q  <= '0;
            lo_q    <= 1'b0;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            lane_q  <= lane_d;
            lo_q    <= lo_d;
            csum_q  <= csum_d;
        end
    end

    assign bus.address  = addr_q;
    assign bus.we       = 1'b0;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_weight_ram_upload.sv
// Bench for weight_ram_upload: RAM model, expected-byte queue filled at stimulus time,
// and a negedge monitor that pops and compares on every accepted byte.
module tb_weight_ram_upload;
    localparam int N     = 10;
    localparam int W     = 10;
    localparam int AW    = 7;
    localparam int DEPTH = 2 ** AW;
    localparam int FRAME = 2 + 2 * N * DEPTH;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic [2:0] state_dbg;

    weight_ram_upload_if #(.N(N), .W(W), .AW(AW)) bus ();

    weight_ram_upload #(.N(N), .W(W), .AW(AW), .HDR(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with one-cycle read latency
    logic [N*W-1:0] mem [DEPTH];
    always @(posedge clk) bus.q <= mem[bus.address];

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        bus.tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         hdr_cyc = -1;
    int         stall_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [2:0] prev_state = 3'd0;

    always @(negedge clk) begin
        logic [7:0] e;
        checks++;
        if (bus.we !== 1'b0) begin
            errors++;
            $display("FAIL we_low got %b expected 0", bus.we);
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b data=%h expected valid=1 data=%h",
                             bus.tx_valid, bus.tx_data, prev_data);
                end
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                got_q.push_back(bus.tx_data);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %h expected none", bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.tx_data !== e) begin
                        errors++;
                        $display("FAIL stream_byte #%0d got %h expected %h",
                                 got_q.size() - 1, bus.tx_data, e);
                    end
                end
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready !== 1'b1) stall_cnt++;
            prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
            prev_data  = bus.tx_data;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (state_dbg == ST_HDR && prev_state != ST_HDR) hdr_cyc = cyc;
        end
        prev_state = state_dbg;
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 8'hxx;
    endfunction

    task automatic fill_pattern();
        for (int a = 0; a < DEPTH; a++)
            for (int i = 0; i < N; i++)
                mem[a][i*W +: W] = W'((a * N + i) % (2 ** W));
    endtask

    task automatic fill_const(input logic [W-1:0] v);
        for (int a = 0; a < DEPTH; a++)
            for (int i = 0; i < N; i++)
                mem[a][i*W +: W] = v;
    endtask

    task automatic push_frame();
        logic [7:0]  cs;
        logic [15:0] ext;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int a = 0; a < DEPTH; a++) begin
            for (int i = 0; i < N; i++) begin
                ext = 16'(mem[a][i*W +: W]);
                exp_q.push_back(ext[15:8]);
                exp_q.push_back(ext[7:0]);
                cs = cs + ext[15:8] + ext[7:0];
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == c0) begin
            errors++;
            $display("FAIL done_timeout got no done after %0d cycles expected done", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int d1;
        int n;

        fill_pattern();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_address", 32'(bus.address), 0);
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk); #1 rst = 1'b0;

        // ascending pattern, sink always ready
        got_q.delete();
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_done(4000);
        check("t1_queue_empty", 32'(exp_q.size()), 0);
        check("t1_len", 32'(got_q.size()), FRAME);
        check("t1_latency", 32'(done_cyc - hdr_cyc), 2 + DEPTH * (2 + 2 * N));
        check("t1_hdr", 32'(got_at(0)), 32'h A5);
        check("t1_a0l1_hi", 32'(got_at(3)), 32'h00);
        check("t1_a0l1_lo", 32'(got_at(4)), 32'h01);
        check("t1_a1l0_lo", 32'(got_at(22)), 32'h0A);
        check("t1_last_lo", 32'(got_at(2560)), 32'hFF);
        check("t1_checksum", 32'(got_at(2561)), 32'h80);
        repeat (20) @(negedge clk);
        check("t1_done_once", 32'(done_cnt - d0), 1);

        // all lanes at max value
        fill_const(10'h3FF);
        got_q.delete();
        push_frame();
        pulse_start();
        wait_done(4000);
        check("t2_queue_empty", 32'(exp_q.size()), 0);
        check("t2_hi", 32'(got_at(1)), 32'h03);
        check("t2_lo", 32'(got_at(2)), 32'hFF);
        check("t2_checksum", 32'(got_at(FRAME - 1)), 32'h00);

        // 30% ready duty
        fill_pattern();
        ready_mode = 1;
        stall_cnt = 0;
        push_frame();
        pulse_start();
        wait_done(20000);
        ready_mode = 0;
        check("t3_queue_empty", 32'(exp_q.size()), 0);
        check("t3_stalls_seen", 32'(stall_cnt > 100), 1);

        // reset during SEND of address 40
        push_frame();
        pulse_start();
        n = 0;
        @(negedge clk);
        while (!(state_dbg == ST_SEND && bus.address == AW'(40)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_addr40", 32'(bus.address), 40);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t4_tx_valid", 32'(bus.tx_valid), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_address", 32'(bus.address), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("t4_stays_idle", 32'(state_dbg), 32'(ST_IDLE));
        got_q.delete();
        push_frame();
        pulse_start();
        wait_done(4000);
        check("t4_queue_empty", 32'(exp_q.size()), 0);
        check("t4_restart_hdr", 32'(got_at(0)), 32'hA5);
        check("t4_restart_a0", 32'(got_at(2)), 32'h00);

        // start pulsed while busy is ignored
        d0 = done_cnt;
        push_frame();
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        wait_done(4000);
        repeat (10) @(negedge clk);
        check("t5_queue_empty", 32'(exp_q.size()), 0);
        check("t5_one_frame", 32'(done_cnt - d0), 1);

        // start held high through DONE launches a back-to-back frame
        push_frame();
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        wait_done(4000);
        d1 = done_cyc;
        check("t6_second_pending", 32'(exp_q.size()), FRAME);
        n = 0;
        while (hdr_cyc <= d1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_restart_gap", 32'(hdr_cyc - d1), 2);
        @(posedge clk); #1 start = 1'b0;
        wait_done(4000);
        repeat (10) @(negedge clk);
        check("t6_queue_empty", 32'(exp_q.size()), 0);
        check("t6_idle_after", 32'(state_dbg), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
